// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder slice, LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_load;
  logic             carry_init;
  logic             ha0_s, ha0_c, ha1_s, ha1_c, slice_c;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; final carry set means no borrow
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  assign ha0_s   = a_sr[0] ^ b_sr[0];
  assign ha0_c   = a_sr[0] & b_sr[0];
  assign ha1_s   = ha0_s ^ carry;
  assign ha1_c   = ha0_s & carry;
  assign slice_c = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_init;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_sr <= {ha1_s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= slice_c;
          cnt    <= cnt + CW'(1);
          // visible result is only updated once the last bit is in
          if (cnt == LAST) begin
            sum   <= {ha1_s, sum_sr[WIDTH-1:1]};
            cout  <= slice_c;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller for WIDTH-bit operands.
- Shares a single 1-bit full-adder slice across all bit positions, LSB-first, one bit per clock. The slice is two 1-bit half-adder cells plus an OR on the two carries.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- Used by lab top levels that need multi-bit addition without a ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry, held with sum

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flip-flop and counter all 0.
- States: IDLE, RUN, DONE. Counter width is clog2(WIDTH)+1.
- IDLE:
  - start=1 at an edge: load a and b into shift regs, carry<=0, cnt<=0, state<=RUN.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - Slice inputs are LSB(a_sr), LSB(b_sr) and carry.
  - Slice sum bit is shifted into the MSB of the sum register (right shift). After WIDTH shifts, bit 0 holds the LSB result.
  - a_sr and b_sr shift right by 1. carry<=slice carry. cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: state<=DONE, cout<=slice carry.
- busy = (state==RUN), decoded from state.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 at the edge: accepted as a new request (same load as IDLE), state<=RUN.
  - start=0 at the edge: state<=IDLE.
- Latency: start accepted at edge E0. Bits are processed on edges E1..EWIDTH. done is high in the cycle after edge EWIDTH. Total is WIDTH+1 cycles from the accepting edge to done.
- start while busy=1 is ignored; it is neither queued nor does it alter operands.
- a and b may change freely after the accepting edge.
- sum and cout change only on the final RUN edge and on reset.
- The sum register shifts internally during RUN. The visible sum output is a separate holding register, updated when RUN ends, so it is stable during RUN.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1).
- Reset mid-operation: immediate return to reset values. The partial result is discarded and no done pulse is produced.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit) is sampled with start.
  - sub=1: b_sr loads ~b and carry initializes to 1, so the result is a-b.
  - cout=1 means no borrow (a>=b unsigned).
  - sub=0: plain addition.
- When undefined:
  - No sub port; carry always initializes to 0.
  - Logic is identical to add-only.

Test Plan:
- WIDTH=8, a=0x3C, b=0x05, start pulse:
  - busy high for 8 cycles.
  - done pulses in the cycle after the 8th RUN edge.
  - sum=0x41, cout=0.
- a=0xFF, b=0x01:
  - sum=0x00, cout=1.
  - done exactly 9 cycles after the accepting edge.
- Start 0x10+0x20, then at the 3rd busy cycle assert start with a=0xFF, b=0xFF:
  - The second start is ignored.
  - Result sum=0x30, cout=0.
  - No second done pulse.
- Start 0xAA+0x55, assert rst_n=0 at the 4th busy cycle:
  - busy, done, sum and cout are 0 immediately.
  - After release, a new 0x01+0x01 gives sum=0x02.
- Back-to-back: start held high through the DONE cycle with new operands 0x80+0x80:
  - First result is valid with done=1.
  - Next edge enters RUN.
  - Second result is sum=0x00, cout=1.
- SERIAL_ADDER_SUB_EN:
  - sub=1, a=0x05, b=0x07 gives sum=0xFE, cout=0.
  - sub=1, a=0x07, b=0x05 gives sum=0x02, cout=1.
